enigma_rotor_sched: RTL and testbench

Sequencer for the 5-bit Enigma substitution path. Accepts one symbol per valid/ready transaction, steps three rotor positions (odometer with double-step), then time-multiplexes a single shared external combinational substitution datapath through 7 passes: 3 forward rotors, reflector, 3 reverse rotors. It sits between the character I/O front end and the rotor/reflector wiring blocks, and owns all rotor-position state.

---
 rtl/enigma_rotor_sched_if.sv | 27 ++
 rtl/enigma_rotor_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_enigma_rotor_sched.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enigma_rotor_sched_if.sv
// Symbol stream in/out plus the shared substitution datapath port of the rotor sequencer.
// The slave view belongs to the sequencer; the master view belongs to its environment.
interface enigma_rotor_sched_if;
  localparam int unsigned SW = 5;
  localparam int unsigned KW = 3;

  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_data;
  logic          out_err;
  logic [KW-1:0] sub_sel;
  logic [SW-1:0] sub_in;
  logic [SW-1:0] sub_out;

  modport master (
    output in_valid, in_data, out_ready, sub_out,
    input  in_ready, out_valid, out_data, out_err, sub_sel, sub_in
  );

  modport slave (
    input  in_valid, in_data, out_ready, sub_out,
    output in_ready, out_valid, out_data, out_err, sub_sel, sub_in
  );
endinterface

// File: rtl/enigma_rotor_sched.sv
// Enigma rotor sequencer: steps three rotors per symbol (with double-step) and drives
// one shared substitution datapath through 3 forward, reflector and 3 reverse passes.
module enigma_rotor_sched #(
  parameter int unsigned ALPHA  = 26,
  parameter int unsigned NOTCH0 = 16,
  parameter int unsigned NOTCH1 = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  enigma_rotor_sched_if.slave     bus,
  input  logic                    cfg_load,
  input  logic [4:0]              cfg_pos0,
  input  logic [4:0]              cfg_pos1,
  input  logic [4:0]              cfg_pos2,
  output logic [4:0]              pos0,
  output logic [4:0]              pos1,
  output logic [4:0]              pos2,
  output logic                    busy
);

  localparam int unsigned SW     = 5;
  localparam int unsigned AW     = SW + 1;
  localparam int unsigned KW     = 3;
  localparam int unsigned NPASS  = 7;
  localparam int unsigned REFL_K = 3;

  localparam logic [AW-1:0] ALPHA_W = AW'(ALPHA);
  localparam logic [SW-1:0] N0      = SW'(NOTCH0);
  localparam logic [SW-1:0] N1      = SW'(NOTCH1);
  localparam logic [KW-1:0] LAST_K  = KW'(NPASS - 1);
  localparam logic [KW-1:0] REFL_KV = KW'(REFL_K);
  localparam logic [SW-1:0] ONE     = SW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_PASS,
    S_DONE
  } state_t;

  // (a + b) mod ALPHA for operands already below ALPHA
  function automatic logic [SW-1:0] add_mod(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [AW-1:0] s;
    s = AW'(a) + AW'(b);
    if (s >= ALPHA_W) s = s - ALPHA_W;
    return SW'(s);
  endfunction

  // (a - b) mod ALPHA; a may exceed ALPHA when the datapath misbehaves
  function automatic logic [SW-1:0] sub_mod(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [AW-1:0] d;
    d = AW'(a) - AW'(b);
    if (a < b) d = d + ALPHA_W;
    return SW'(d);
  endfunction

  function automatic logic [SW-1:0] cfg_mod(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    r = v;
    if (AW'(v) >= ALPHA_W) r = SW'(AW'(v) - ALPHA_W);
    return r;
  endfunction

  // Rotor position used by pass k: 0,1,2 forward, 6,5,4 on the way back
  function automatic logic [SW-1:0] pos_for(input logic [KW-1:0] k,
                                            input logic [SW-1:0] p0,
                                            input logic [SW-1:0] p1,
                                            input logic [SW-1:0] p2);
    logic [SW-1:0] p;
    case (k)
      3'd1, 3'd5: p = p1;
      3'd2, 3'd4: p = p2;
      3'd3:       p = '0;
      default:    p = p0;
    endcase
    return p;
  endfunction

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [SW-1:0] x_q, x_d;
  logic          err_q, err_d;
  logic [SW-1:0] pos0_q, pos0_d;
  logic [SW-1:0] pos1_q, pos1_d;
  logic [SW-1:0] pos2_q, pos2_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] out_data_q, out_data_d;
  logic          out_err_q, out_err_d;
  logic [KW-1:0] sub_sel_q, sub_sel_d;
  logic [SW-1:0] sub_in_q, sub_in_d;
  logic          busy_q, busy_d;
  logic [SW-1:0] pass_p;
  logic [SW-1:0] next_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      x_q         <= '0;
      err_q       <= 1'b0;
      pos0_q      <= '0;
      pos1_q      <= '0;
      pos2_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      sub_sel_q   <= '0;
      sub_in_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      x_q         <= x_d;
      err_q       <= err_d;
      pos0_q      <= pos0_d;
      pos1_q      <= pos1_d;
      pos2_q      <= pos2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      sub_sel_q   <= sub_sel_d;
      sub_in_q    <= sub_in_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    x_d         = x_q;
    err_d       = err_q;
    pos0_d      = pos0_q;
    pos1_d      = pos1_q;
    pos2_d      = pos2_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    sub_sel_d   = '0;
    sub_in_d    = '0;
    busy_d      = 1'b0;
    next_p      = '0;
    pass_p      = pos_for(k_q, pos0_q, pos1_q, pos2_q);

    case (state_q)
      S_IDLE: begin
        if (cfg_load) begin
          pos0_d = cfg_mod(cfg_pos0);
          pos1_d = cfg_mod(cfg_pos1);
          pos2_d = cfg_mod(cfg_pos2);
        end else if (bus.in_valid) begin
          err_d = 1'b0;
          if (AW'(bus.in_data) >= ALPHA_W) begin
            // Illegal symbol bypasses stepping and passes entirely
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data;
            out_err_d   = 1'b1;
          end else begin
            x_d     = bus.in_data;
            state_d = S_STEP;
          end
        end
      end

      S_STEP: begin
        // Odometer with the middle-rotor double-step, all on pre-step values
        pos0_d = add_mod(pos0_q, ONE);
        if (pos0_q == N0 || pos1_q == N1) pos1_d = add_mod(pos1_q, ONE);
        if (pos1_q == N1)                 pos2_d = add_mod(pos2_q, ONE);
        k_d     = '0;
        state_d = S_PASS;
      end

      S_PASS: begin
        if (k_q == REFL_KV) x_d = bus.sub_out;
        else                x_d = sub_mod(bus.sub_out, pass_p);
        if (AW'(bus.sub_out) >= ALPHA_W) err_d = 1'b1;
        if (k_q == LAST_K) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_data_d  = x_d;
          out_err_d   = err_d;
        end else begin
          k_d = k_q + 3'd1;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          err_d       = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Datapath operands are registered one edge ahead so they are stable for the whole pass
    if (state_d == S_PASS) begin
      next_p    = pos_for(k_d, pos0_d, pos1_d, pos2_d);
      sub_sel_d = k_d;
      sub_in_d  = (k_d == REFL_KV) ? x_d : add_mod(x_d, next_p);
    end
    busy_d = (state_d != S_IDLE);
  end

  // Readiness must drop in the very cycle cfg_load is raised, hence combinational
  assign bus.in_ready  = (state_q == S_IDLE) && !cfg_load;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;
  assign bus.sub_sel   = sub_sel_q;
  assign bus.sub_in    = sub_in_q;
  assign pos0          = pos0_q;
  assign pos1          = pos1_q;
  assign pos2          = pos2_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_enigma_rotor_sched.sv
// Randomized bench for enigma_rotor_sched against a plain-arithmetic Enigma model
// with selectable datapath stubs (identity, rotor wirings, faulty reflector).
module tb_enigma_rotor_sched;
  localparam int ALPHA  = 26;
  localparam int NOTCH0 = 16;
  localparam int NOTCH1 = 4;
  localparam int MODE_IDENT    = 0;
  localparam int MODE_ROTOR    = 1;
  localparam int MODE_BAD_REFL = 2;
  localparam int NSYM = 32;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       cfg_load = 1'b0;
  logic [4:0] cfg_pos0 = '0;
  logic [4:0] cfg_pos1 = '0;
  logic [4:0] cfg_pos2 = '0;
  logic [4:0] pos0, pos1, pos2;
  logic       busy;

  enigma_rotor_sched_if bus();

  enigma_rotor_sched #(.ALPHA(ALPHA), .NOTCH0(NOTCH0), .NOTCH1(NOTCH1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cfg_load (cfg_load),
    .cfg_pos0 (cfg_pos0),
    .cfg_pos1 (cfg_pos1),
    .cfg_pos2 (cfg_pos2),
    .pos0     (pos0),
    .pos1     (pos1),
    .pos2     (pos2),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int mode     = MODE_IDENT;

  int fw  [3][26];
  int inv [3][26];
  int refl[26];
  int mp  [3];

  int         lat;
  logic [4:0] od;
  logic       oe;
  int         sel_log[16];
  int         sin_log[16];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Shared substitution datapath stand-in
  logic [4:0] sout;
  always_comb begin
    sout = bus.sub_in;
    if (mode == MODE_ROTOR && int'(bus.sub_in) < ALPHA) begin
      case (bus.sub_sel)
        3'd0:    sout = 5'(fw[0][bus.sub_in]);
        3'd1:    sout = 5'(fw[1][bus.sub_in]);
        3'd2:    sout = 5'(fw[2][bus.sub_in]);
        3'd3:    sout = 5'(refl[bus.sub_in]);
        3'd4:    sout = 5'(inv[2][bus.sub_in]);
        3'd5:    sout = 5'(inv[1][bus.sub_in]);
        3'd6:    sout = 5'(inv[0][bus.sub_in]);
        default: sout = bus.sub_in;
      endcase
    end else if (mode == MODE_BAD_REFL && bus.sub_sel == 3'd3) begin
      sout = 5'd31;
    end
  end
  assign bus.sub_out = sout;

  function automatic void build_wiring();
    string w[3];
    w[0] = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    w[1] = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    w[2] = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < ALPHA; i++) begin
        fw[r][i] = int'(w[r][i]) - 65;
        inv[r][fw[r][i]] = i;
      end
    for (int i = 0; i < ALPHA; i++) refl[i] = (i + 13) % ALPHA;
  endfunction

  // Odometer rule on the model's rotor positions
  function automatic void model_step();
    bit s1, s2;
    s1 = (mp[0] == NOTCH0) || (mp[1] == NOTCH1);
    s2 = (mp[1] == NOTCH1);
    mp[0] = (mp[0] + 1) % ALPHA;
    if (s1) mp[1] = (mp[1] + 1) % ALPHA;
    if (s2) mp[2] = (mp[2] + 1) % ALPHA;
  endfunction

  function automatic int model_enc(input int c_in);
    int c;
    c = c_in;
    for (int r = 0; r < 3; r++)  c = (fw[r][(c + mp[r]) % ALPHA] - mp[r] + ALPHA) % ALPHA;
    c = refl[c];
    for (int r = 2; r >= 0; r--) c = (inv[r][(c + mp[r]) % ALPHA] - mp[r] + ALPHA) % ALPHA;
    return c;
  endfunction

  task automatic check_pos(input string tag);
    check({tag, "_pos0"}, int'(pos0), mp[0]);
    check({tag, "_pos1"}, int'(pos1), mp[1]);
    check({tag, "_pos2"}, int'(pos2), mp[2]);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  int'(bus.in_ready),  1);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_out_data"},  int'(bus.out_data),  0);
    check({tag, "_out_err"},   int'(bus.out_err),   0);
    check({tag, "_sub_sel"},   int'(bus.sub_sel),   0);
    check({tag, "_sub_in"},    int'(bus.sub_in),    0);
    check({tag, "_busy"},      int'(busy),          0);
    check({tag, "_pos0"},      int'(pos0),          0);
    check({tag, "_pos1"},      int'(pos1),          0);
    check({tag, "_pos2"},      int'(pos2),          0);
  endtask

  // Load start positions with a competing in_valid, which must lose
  task automatic load_cfg(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    @(negedge clk);
    cfg_load = 1'b1;
    cfg_pos0 = a; cfg_pos1 = b; cfg_pos2 = c;
    bus.in_valid = 1'b1;
    bus.in_data  = 5'(($urandom % 26));
    #1 check("cfg_in_ready", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    cfg_load = 1'b0;
    bus.in_valid = 1'b0;
    mp[0] = int'(a) % ALPHA;
    mp[1] = int'(b) % ALPHA;
    mp[2] = int'(c) % ALPHA;
    check("cfg_no_accept", int'(busy), 0);
    check_pos("cfg");
  endtask

  // One symbol through the DUT; hold>0 keeps out_ready low that many cycles once output is up
  task automatic xfer(input logic [4:0] sym, input int hold);
    int n;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = sym;
    bus.out_ready = (hold == 0);
    n = 0;
    while (!bus.in_ready && n < 40) begin @(negedge clk); n++; end
    check("in_ready_wait", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      if (lat < 16) begin sel_log[lat] = int'(bus.sub_sel); sin_log[lat] = int'(bus.sub_in); end
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_wait", int'(bus.out_valid), 1);
    od = bus.out_data;
    oe = bus.out_err;
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin cfg_load = 1'b1; cfg_pos0 = 5'd9; cfg_pos1 = 5'd9; cfg_pos2 = 5'd9; end
      if (i == 2) cfg_load = 1'b0;
      @(posedge clk); #1;
      check("bp_out_valid", int'(bus.out_valid), 1);
      check("bp_out_data",  int'(bus.out_data),  int'(od));
      check("bp_out_err",   int'(bus.out_err),   int'(oe));
      check("bp_in_ready",  int'(bus.in_ready),  0);
    end
    if (hold > 0) begin
      cfg_load = 1'b0;
      check_pos("bp");
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("post_out_in_ready", int'(bus.in_ready), 1);
    check("post_out_valid",    int'(bus.out_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] sym;
    int plain[NSYM];
    int cipher[NSYM];

    build_wiring();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    mp = '{0, 0, 0};

    repeat (3) @(posedge clk);
    #1 check_reset_vals("por");
    @(negedge clk) rst_n = 1'b1;

    // Reset while passes are in flight
    load_cfg(5'd3, 5'd4, 5'd5);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 5'd10;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("pre_rst_sub_sel", int'(bus.sub_sel), 3);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mid_rst");
    @(negedge clk) rst_n = 1'b1;
    mp = '{0, 0, 0};
    #1 check("rst_release_in_ready", int'(bus.in_ready), 1);

    // Identity datapath: timing, pass order and first operand
    mode = MODE_IDENT;
    load_cfg(5'd0, 5'd0, 5'd0);
    model_step();
    xfer(5'd7, 0);
    check("id_data", int'(od), 7);
    check("id_err", int'(oe), 0);
    check("id_latency", lat, 9);
    check_pos("id");
    check("id_step_sub_in", sin_log[1], 0);
    for (int k = 0; k < 7; k++) check($sformatf("id_sel_k%0d", k), sel_log[2 + k], k);
    check("id_sub_in_k0", sin_log[2], 8);

    // Stepping incl. double-step and wrap
    load_cfg(5'd16, 5'd3, 5'd0);
    for (int i = 0; i < 2; i++) begin
      sym = 5'($urandom_range(0, 25));
      model_step();
      xfer(sym, 0);
      check("step_data", int'(od), int'(sym));
      check_pos("step");
    end
    check("dstep_pos2", int'(pos2), 1);
    load_cfg(5'd25, 5'd25, 5'd25);
    model_step();
    xfer(5'($urandom_range(0, 25)), 0);
    check_pos("wrap");
    load_cfg(5'd30, 5'd26, 5'd31);
    check("cfg_mod_pos0", int'(pos0), 4);

    // Backpressure with an ignored cfg_load
    sym = 5'($urandom_range(0, 25));
    model_step();
    xfer(sym, 5);
    check("bp_data", int'(od), int'(sym));

    // Illegal symbols: immediate error, positions untouched
    xfer(5'd30, 0);
    check("ill30_data", int'(od), 30);
    check("ill30_err", int'(oe), 1);
    check("ill30_latency", lat, 1);
    check_pos("ill30");
    xfer(5'd26, 0);
    check("ill26_err", int'(oe), 1);
    check("ill26_data", int'(od), 26);
    sym = 5'd25;
    model_step();
    xfer(sym, 0);
    check("legal_after_ill_err", int'(oe), 0);
    check("legal_after_ill_data", int'(od), 25);

    // Datapath returning 31 on the reflector pass
    mode = MODE_BAD_REFL;
    model_step();
    xfer(5'($urandom_range(0, 25)), 0);
    check("badrefl_err", int'(oe), 1);
    check("badrefl_latency", lat, 9);
    mode = MODE_IDENT;
    sym = 5'($urandom_range(0, 25));
    model_step();
    xfer(sym, 0);
    check("err_cleared", int'(oe), 0);
    check("err_cleared_data", int'(od), int'(sym));

    // Real wirings against the golden model, then decrypt from the same start
    mode = MODE_ROTOR;
    load_cfg(5'd0, 5'd0, 5'd0);
    for (int i = 0; i < NSYM; i++) begin
      plain[i] = int'($urandom_range(0, 25));
      model_step();
      cipher[i] = model_enc(plain[i]);
      xfer(5'(plain[i]), 0);
      check($sformatf("enc_%0d", i), int'(od), cipher[i]);
      check("enc_err", int'(oe), 0);
    end
    check_pos("enc_end");
    load_cfg(5'd0, 5'd0, 5'd0);
    for (int i = 0; i < NSYM; i++) begin
      model_step();
      xfer(5'(cipher[i]), ($urandom % 4 == 0) ? 2 : 0);
      check($sformatf("dec_%0d", i), int'(od), plain[i]);
    end

    // Random start positions
    load_cfg(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    for (int i = 0; i < 16; i++) begin
      sym = 5'($urandom_range(0, 25));
      model_step();
      xfer(sym, 0);
      check($sformatf("rnd_%0d", i), int'(od), model_enc(int'(sym)));
      check_pos("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
